axi_master_arb_aw_w: RTL and testbench

//  Write-path arbiter between masters m0..m2 and the single slave-side write channel.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/rr_arb3.sv | 33 +++
 rtl/axi_master_arb_aw_w.sv | 209 ++++++++++++++++++++
 tb/tb_axi_master_arb_aw_w.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI write/read arbitration types: FSM states, master ID tags, ID helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_AW, ARB_W, ARB_B} arb_state_e;

    // Master tags placed on awid/arid; the B/R muxes decode the same values.
    localparam logic [7:0] MID_M0 = 8'h00;
    localparam logic [7:0] MID_M1 = 8'h01;
    localparam logic [7:0] MID_M2 = 8'h02;

    function automatic logic [7:0] mid_of(input logic [1:0] idx);
        case (idx)
            2'd1:    mid_of = MID_M1;
            2'd2:    mid_of = MID_M2;
            default: mid_of = MID_M0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin picker: first requester at or after ptr (0->1->2->0).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req[2:0] requests, ptr[1:0] priority start (3 treated as 0),
//        gnt_onehot[2:0] winner, gnt_idx[1:0] winner index, any = at least one request.
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [2:0] mask;
    logic [2:0] masked;
    logic [2:0] cand;

    always_comb begin
        // Mask off requesters below ptr; if none remain, wrap to the full set.
        case (ptr)
            2'd1:    mask = 3'b110;
            2'd2:    mask = 3'b100;
            default: mask = 3'b111;
        endcase
        masked     = req & mask;
        cand       = (|masked) ? masked : req;
        // Isolate the lowest set bit of the candidate set.
        gnt_onehot = cand & (~cand + 3'd1);
        gnt_idx    = gnt_onehot[2] ? 2'd2 : (gnt_onehot[1] ? 2'd1 : 2'd0);
        any        = |req;
    end

endmodule

// File: rtl/axi_master_arb_aw_w.sv
// Write-path arbiter m0..m2 -> one slave AW/W channel; grant held until matching B is snooped.
// Latency: AW registered (1 cycle after master handshake); W combinational pass-through.
// Backpressure: AWREADY only to the IDLE winner; W ready mirrors slave wready for the granted master only.
// Ports: clk_i/rst_i (sync, active-high); mN_AW*/mN_W* master side; aw*/w* slave side; bid/bvalid/bready snooped.
module axi_master_arb_aw_w #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   m0_AWADDR,
    input  logic [7:0]          m0_AWLEN,
    input  logic [2:0]          m0_AWSIZE,
    input  logic [1:0]          m0_AWBURST,
    input  logic                m0_AWVALID,
    output logic                m0_AWREADY,
    input  logic [DATA_W-1:0]   m0_WDATA,
    input  logic [DATA_W/8-1:0] m0_WSTRB,
    input  logic                m0_WLAST,
    input  logic                m0_WVALID,
    output logic                m0_WREADY,
    input  logic [ADDR_W-1:0]   m1_AWADDR,
    input  logic [7:0]          m1_AWLEN,
    input  logic [2:0]          m1_AWSIZE,
    input  logic [1:0]          m1_AWBURST,
    input  logic                m1_AWVALID,
    output logic                m1_AWREADY,
    input  logic [DATA_W-1:0]   m1_WDATA,
    input  logic [DATA_W/8-1:0] m1_WSTRB,
    input  logic                m1_WLAST,
    input  logic                m1_WVALID,
    output logic                m1_WREADY,
    input  logic [ADDR_W-1:0]   m2_AWADDR,
    input  logic [7:0]          m2_AWLEN,
    input  logic [2:0]          m2_AWSIZE,
    input  logic [1:0]          m2_AWBURST,
    input  logic                m2_AWVALID,
    output logic                m2_AWREADY,
    input  logic [DATA_W-1:0]   m2_WDATA,
    input  logic [DATA_W/8-1:0] m2_WSTRB,
    input  logic                m2_WLAST,
    input  logic                m2_WVALID,
    output logic                m2_WREADY,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic                bvalid,
    input  logic                bready
);
    import axi_pkg::*;

    arb_state_e          state_q;
    logic [1:0]          grant_q;
    logic [1:0]          rr_ptr_q;
    logic [ID_W-1:0]     awid_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [7:0]          awlen_q;
    logic [2:0]          awsize_q;
    logic [1:0]          awburst_q;
    logic                awvalid_q;

    logic [2:0]          req;
    logic [2:0]          gnt_oh;
    logic [1:0]          gnt_idx;
    logic                gnt_any;
    logic                arb_en;
    logic                w_phase;

    logic [ADDR_W-1:0]   sel_awaddr;
    logic [7:0]          sel_awlen;
    logic [2:0]          sel_awsize;
    logic [1:0]          sel_awburst;
    logic                sel_wvalid;

    assign req = {m2_AWVALID, m1_AWVALID, m0_AWVALID};

    rr_arb3 u_rr_arb3 (
        .req        (req),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_oh),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // Ready/valid are gated by rst_i so nothing handshakes while reset is held.
    assign arb_en  = (state_q == ARB_IDLE) && !rst_i;
    assign w_phase = (state_q == ARB_W) && !rst_i;

    assign m0_AWREADY = arb_en & gnt_oh[0];
    assign m1_AWREADY = arb_en & gnt_oh[1];
    assign m2_AWREADY = arb_en & gnt_oh[2];

    assign m0_WREADY = w_phase && (grant_q == 2'd0) && wready;
    assign m1_WREADY = w_phase && (grant_q == 2'd1) && wready;
    assign m2_WREADY = w_phase && (grant_q == 2'd2) && wready;

    always_comb begin
        sel_awaddr  = m0_AWADDR;
        sel_awlen   = m0_AWLEN;
        sel_awsize  = m0_AWSIZE;
        sel_awburst = m0_AWBURST;
        case (gnt_idx)
            2'd1: begin
                sel_awaddr  = m1_AWADDR;
                sel_awlen   = m1_AWLEN;
                sel_awsize  = m1_AWSIZE;
                sel_awburst = m1_AWBURST;
            end
            2'd2: begin
                sel_awaddr  = m2_AWADDR;
                sel_awlen   = m2_AWLEN;
                sel_awsize  = m2_AWSIZE;
                sel_awburst = m2_AWBURST;
            end
            default: ;
        endcase
    end

    always_comb begin
        sel_wvalid = m0_WVALID;
        wdata      = m0_WDATA;
        wstrb      = m0_WSTRB;
        wlast      = m0_WLAST;
        case (grant_q)
            2'd1: begin
                sel_wvalid = m1_WVALID;
                wdata      = m1_WDATA;
                wstrb      = m1_WSTRB;
                wlast      = m1_WLAST;
            end
            2'd2: begin
                sel_wvalid = m2_WVALID;
                wdata      = m2_WDATA;
                wstrb      = m2_WSTRB;
                wlast      = m2_WLAST;
            end
            default: ;
        endcase
    end

    assign wvalid  = w_phase & sel_wvalid;
    assign awid    = awid_q;
    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign awburst = awburst_q;
    assign awvalid = awvalid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            grant_q   <= 2'd0;
            rr_ptr_q  <= 2'd0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            awvalid_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    // The winner always has AWVALID high, so a pick is a handshake.
                    if (gnt_any) begin
                        awaddr_q  <= sel_awaddr;
                        awlen_q   <= sel_awlen;
                        awsize_q  <= sel_awsize;
                        awburst_q <= sel_awburst;
                        awid_q    <= ID_W'(mid_of(gnt_idx));
                        grant_q   <= gnt_idx;
                        awvalid_q <= 1'b1;
                        state_q   <= ARB_AW;
                    end
                end
                ARB_AW: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ARB_W;
                    end
                end
                ARB_W: begin
                    if (wvalid && wready && wlast) begin
                        state_q <= ARB_B;
                    end
                end
                ARB_B: begin
                    // awid_q carries the grant tag, so it is the id to match.
                    if (bvalid && bready && (bid == awid_q)) begin
                        rr_ptr_q <= (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
                        state_q  <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_arb_aw_w.sv
module tb_axi_master_arb_aw_w;

    logic        clk;
    logic        rst;
    logic [31:0] m_awaddr  [3];
    logic [7:0]  m_awlen   [3];
    logic [2:0]  m_awsize  [3];
    logic [1:0]  m_awburst [3];
    logic [31:0] m_wdata   [3];
    logic [3:0]  m_wstrb   [3];
    logic [2:0]  m_awvalid;
    logic [2:0]  m_wvalid;
    logic [2:0]  m_wlast;
    wire  [2:0]  m_awready;
    wire  [2:0]  m_wready;

    wire  [7:0]  awid;
    wire  [31:0] awaddr;
    wire  [7:0]  awlen;
    wire  [2:0]  awsize;
    wire  [1:0]  awburst;
    wire         awvalid;
    logic        awready;
    wire  [31:0] wdata;
    wire  [3:0]  wstrb;
    wire         wlast;
    wire         wvalid;
    logic        wready;
    logic [7:0]  bid;
    logic        bvalid;
    logic        bready;

    int errors;
    int checks;
    int model_ptr;   // round-robin start point expected from the rules

    axi_master_arb_aw_w #(.ADDR_W(32), .DATA_W(32), .ID_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_AWADDR(m_awaddr[0]), .m0_AWLEN(m_awlen[0]), .m0_AWSIZE(m_awsize[0]),
        .m0_AWBURST(m_awburst[0]), .m0_AWVALID(m_awvalid[0]), .m0_AWREADY(m_awready[0]),
        .m0_WDATA(m_wdata[0]), .m0_WSTRB(m_wstrb[0]), .m0_WLAST(m_wlast[0]),
        .m0_WVALID(m_wvalid[0]), .m0_WREADY(m_wready[0]),
        .m1_AWADDR(m_awaddr[1]), .m1_AWLEN(m_awlen[1]), .m1_AWSIZE(m_awsize[1]),
        .m1_AWBURST(m_awburst[1]), .m1_AWVALID(m_awvalid[1]), .m1_AWREADY(m_awready[1]),
        .m1_WDATA(m_wdata[1]), .m1_WSTRB(m_wstrb[1]), .m1_WLAST(m_wlast[1]),
        .m1_WVALID(m_wvalid[1]), .m1_WREADY(m_wready[1]),
        .m2_AWADDR(m_awaddr[2]), .m2_AWLEN(m_awlen[2]), .m2_AWSIZE(m_awsize[2]),
        .m2_AWBURST(m_awburst[2]), .m2_AWVALID(m_awvalid[2]), .m2_AWREADY(m_awready[2]),
        .m2_WDATA(m_wdata[2]), .m2_WSTRB(m_wstrb[2]), .m2_WLAST(m_wlast[2]),
        .m2_WVALID(m_wvalid[2]), .m2_WREADY(m_wready[2]),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference arbitration rule: first requester at or after ptr, order 0->1->2->0.
    function automatic int pick(input int ptr, input logic [2:0] req);
        for (int k = 0; k < 3; k++) begin
            if (req[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic set_payload(input int m);
        m_awaddr[m]  = $urandom;
        m_awlen[m]   = 8'($urandom_range(0, 15));
        m_awsize[m]  = 3'($urandom_range(0, 2));
        m_awburst[m] = 2'($urandom_range(0, 2));
    endtask

    // One complete write for the expected winner exp_m: grant, AW, W beats, B.
    task automatic serve(input int exp_m, input int nbeats, input int aw_stall,
                         input bit wr_rand, input bit wrong_b, input bit keep_req,
                         input logic [2:0] late_req);
        logic [31:0] bd [16];
        logic [3:0]  bs [16];
        logic [31:0] e_addr;
        logic [7:0]  e_len;
        logic [2:0]  e_size;
        logic [1:0]  e_burst;
        logic [7:0]  e_id;
        logic        e_last;
        int          t;
        int          c;
        int          sent;
        bit          done;

        t = 0;
        settle();
        while (m_awready == 3'b000 && t < 20) begin
            step();
            settle();
            t++;
        end
        checks++;
        if (m_awready !== 3'(1 << exp_m)) begin
            errors++;
            $display("FAIL grant_onehot: got %b want %b", m_awready, 3'(1 << exp_m));
            return;
        end
        e_addr  = m_awaddr[exp_m];
        e_len   = m_awlen[exp_m];
        e_size  = m_awsize[exp_m];
        e_burst = m_awburst[exp_m];
        e_id    = 8'(exp_m);
        for (int i = 0; i < nbeats; i++) begin
            bd[i] = $urandom;
            bs[i] = 4'($urandom_range(1, 15));
        end
        step();   // AW handshake with the master
        if (!keep_req) m_awvalid[exp_m] = 1'b0;
        m_awvalid = m_awvalid | late_req;
        // Every master offers W early; none may be accepted before the AW leaves.
        for (int k = 0; k < 3; k++) begin
            m_wdata[k] = $urandom;
            m_wstrb[k] = 4'hF;
            m_wlast[k] = 1'b1;
        end
        m_wvalid = 3'b111;
        m_wdata[exp_m] = bd[0];
        m_wstrb[exp_m] = bs[0];
        m_wlast[exp_m] = (nbeats == 1);

        c = 0;
        done = 1'b0;
        while (!done) begin
            awready = (c >= aw_stall);
            settle();
            checks++;
            if ({awvalid, awid, awaddr, awlen, awsize, awburst} !==
                {1'b1, e_id, e_addr, e_len, e_size, e_burst}) begin
                errors++;
                $display("FAIL aw_payload: got v=%b id=%h a=%h l=%h want v=1 id=%h a=%h l=%h",
                         awvalid, awid, awaddr, awlen, e_id, e_addr, e_len);
            end
            checks++;
            if (m_wready !== 3'b000 || wvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_before_aw: got wready=%b wvalid=%b want 000/0", m_wready, wvalid);
            end
            step();
            if (c >= aw_stall) done = 1'b1;
            c++;
        end
        awready = 1'b0;

        sent = 0;
        t = 0;
        while (sent < nbeats && t < 200) begin
            m_wvalid[exp_m] = wr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_wdata[exp_m]  = bd[sent];
            m_wstrb[exp_m]  = bs[sent];
            e_last          = (sent == nbeats - 1);
            m_wlast[exp_m]  = e_last;
            for (int k = 0; k < 3; k++) begin
                if (k != exp_m) begin
                    m_wvalid[k] = 1'($urandom);
                    m_wdata[k]  = $urandom;
                end
            end
            wready = wr_rand ? (t % 2 == 0) : 1'b1;
            settle();
            checks++;
            if (wvalid !== m_wvalid[exp_m] ||
                m_wready !== (wready ? 3'(1 << exp_m) : 3'b000)) begin
                errors++;
                $display("FAIL w_route: got wvalid=%b wready=%b want wvalid=%b wready=%b",
                         wvalid, m_wready, m_wvalid[exp_m], wready ? 3'(1 << exp_m) : 3'b000);
            end
            if (m_wvalid[exp_m] && wready) begin
                checks++;
                if ({wdata, wstrb, wlast} !== {bd[sent], bs[sent], e_last}) begin
                    errors++;
                    $display("FAIL w_beat%0d: got %h/%h/%b want %h/%h/%b", sent,
                             wdata, wstrb, wlast, bd[sent], bs[sent], e_last);
                end
                sent++;
            end
            step();
            t++;
        end
        if (sent < nbeats) begin
            errors++;
            $display("FAIL w_timeout: got %0d beats want %0d", sent, nbeats);
        end
        m_wvalid = 3'b000;
        wready   = 1'b0;

        if (wrong_b) begin
            bid    = 8'((exp_m + 2) % 3);
            bvalid = 1'b1;
            bready = 1'b1;
            step();
            bvalid = 1'b0;
            bready = 1'b0;
            settle();
            checks++;
            if (m_awready !== 3'b000 || awvalid !== 1'b0) begin
                errors++;
                $display("FAIL wrong_bid_held: got awready=%b awvalid=%b want 000/0",
                         m_awready, awvalid);
            end
        end
        bid    = 8'(exp_m);
        bvalid = 1'b1;
        bready = 1'b1;
        step();
        bvalid    = 1'b0;
        bready    = 1'b0;
        bid       = 8'h00;
        model_ptr = (exp_m + 1) % 3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) set_payload(k);
        m_awvalid = 3'b111;
        m_wvalid  = 3'b111;
        step();
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (m_awready !== 3'b000 || m_wready !== 3'b000 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: got awr=%b wr=%b awv=%b wv=%b want all 0",
                         m_awready, m_wready, awvalid, wvalid);
            end
            checks++;
            if ({awid, awaddr, awlen, awsize, awburst} !== 53'd0) begin
                errors++;
                $display("FAIL reset_payload: got id=%h addr=%h len=%h want 0", awid, awaddr, awlen);
            end
            step();
        end
        rst       = 1'b0;
        m_wvalid  = 3'b000;
        model_ptr = 0;
        serve(pick(model_ptr, m_awvalid), 2, 0, 1'b0, 1'b0, 1'b0, 3'b000);
        m_awvalid = 3'b000;
    endtask

    task automatic test_single_write();
        m_awaddr[1]  = 32'h1000_0040;
        m_awlen[1]   = 8'd3;
        m_awsize[1]  = 3'd2;
        m_awburst[1] = 2'd1;
        m_awvalid    = 3'b010;
        serve(1, 4, 0, 1'b0, 1'b0, 1'b0, 3'b000);
        settle();
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || m_awready !== 3'b000 || m_wready !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_b: got awv=%b wv=%b awr=%b wr=%b want all 0",
                     awvalid, wvalid, m_awready, m_wready);
        end
        step();
    endtask

    task automatic test_contention();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        model_ptr = 0;
        for (int k = 0; k < 3; k++) set_payload(k);
        m_awvalid = 3'b111;
        // With all three requesting continuously the grant walks 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            serve(i % 3, $urandom_range(1, 4), $urandom_range(0, 2),
                  1'($urandom), 1'b0, 1'b1, 3'b000);
            set_payload((i % 3));
        end
        m_awvalid = 3'b000;
        step();
    endtask

    task automatic test_backpressure();
        set_payload(0);
        m_awvalid = 3'b001;
        serve(pick(model_ptr, m_awvalid), 6, 5, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
    endtask

    task automatic test_wrong_bid();
        set_payload(0);
        set_payload(1);
        m_awvalid = 3'b001;
        // m1 arrives mid-transaction and must wait until the matching B.
        serve(pick(model_ptr, m_awvalid), 3, 1, 1'b0, 1'b1, 1'b0, 3'b010);
        serve(pick(model_ptr, m_awvalid), 2, 0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
    endtask

    task automatic test_mid_reset();
        set_payload(0);
        m_awvalid = 3'b001;
        settle();
        checks++;
        if (m_awready !== 3'(1 << pick(model_ptr, m_awvalid))) begin
            errors++;
            $display("FAIL mid_grant: got %b want %b", m_awready, 3'(1 << pick(model_ptr, m_awvalid)));
        end
        step();
        m_awvalid = 3'b000;
        awready   = 1'b1;
        step();
        awready     = 1'b0;
        m_wvalid[0] = 1'b1;
        m_wlast[0]  = 1'b0;
        wready      = 1'b1;
        for (int b = 0; b < 2; b++) begin
            m_wdata[0] = $urandom;
            settle();
            checks++;
            if (m_wready !== 3'b001) begin
                errors++;
                $display("FAIL mid_beat%0d_ready: got %b want 001", b, m_wready);
            end
            step();
        end
        rst = 1'b1;
        step();
        settle();
        checks++;
        if (m_awready !== 3'b000 || m_wready !== 3'b000 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            {awid, awaddr, awlen, awsize, awburst} !== 53'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got awr=%b wr=%b awv=%b wv=%b id=%h addr=%h want all 0",
                     m_awready, m_wready, awvalid, wvalid, awid, awaddr);
        end
        rst       = 1'b0;
        m_wvalid  = 3'b000;
        wready    = 1'b0;
        model_ptr = 0;
        step();
        // Pointer is back at 0, so m0 beats m2; the pending m2 is served next.
        set_payload(0);
        set_payload(2);
        m_awvalid = 3'b101;
        serve(pick(model_ptr, m_awvalid), 1, 0, 1'b0, 1'b0, 1'b0, 3'b000);
        serve(pick(model_ptr, m_awvalid), 3, 2, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        model_ptr = 0;
        rst       = 1'b1;
        m_awvalid = 3'b000;
        m_wvalid  = 3'b000;
        m_wlast   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            m_awaddr[k]  = '0;
            m_awlen[k]   = '0;
            m_awsize[k]  = '0;
            m_awburst[k] = '0;
            m_wdata[k]   = '0;
            m_wstrb[k]   = '0;
        end
        awready = 1'b0;
        wready  = 1'b0;
        bid     = 8'h00;
        bvalid  = 1'b0;
        bready  = 1'b0;

        test_reset();
        test_single_write();
        test_contention();
        test_backpressure();
        test_wrong_bid();
        test_mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
